// File: rtl/motoro3_pkg.sv
// motoro3_pkg: shared definitions for the 3-phase commutation step sequencer.
// State encoding, step index constants and small step-arithmetic helpers.
package motoro3_pkg;

  // Sequencer state encoding (kept as plain constants for legacy tooling)
  typedef logic [1:0] m3_state_t;
  localparam m3_state_t ST_IDLE  = 2'd0;
  localparam m3_state_t ST_RUN   = 2'd1;
  localparam m3_state_t ST_DRAIN = 2'd2;

  // Commutation step indices
  localparam logic [3:0] STEP_INACTIVE = 4'd15;
  localparam logic [3:0] STEP_FIRST    = 4'd0;
  localparam logic [3:0] STEP_LAST     = 4'd11;
  localparam logic [3:0] STEP_HALF_A   = 4'd5;   // end of first half-cycle
  localparam logic [3:0] STEP_HALF_B   = 4'd11;  // end of second half-cycle

  // Default minimum effective step length in clocks
  localparam int LEN_MIN_DEFAULT = 4;

  // True on the last step of either electrical half-cycle
  function automatic logic is_half_end(input logic [3:0] step);
    return (step == STEP_HALF_A) || (step == STEP_HALF_B);
  endfunction

  // Step index that follows 'step' in the 12-step rotation
  function automatic logic [3:0] next_step(input logic [3:0] step);
    return (step == STEP_LAST) ? STEP_FIRST : step + 4'd1;
  endfunction

endpackage

// File: rtl/motoro3_step_timebase.sv
// motoro3_step_timebase: per-step clock counter, step-length latch with
// LEN_MIN clamp, and first/last strobe decode. Counts on the falling edge.
// The step length is sampled only on start and at step boundaries, so
// mid-step changes of the request never stretch or shorten a running step.
module motoro3_step_timebase
  import motoro3_pkg::*;
#(
  parameter int CNT_W   = 25,
  parameter int LEN_MIN = LEN_MIN_DEFAULT
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             i_start,    // IDLE exit: restart count, latch length
  input  logic             i_active,   // sequencer in RUN or DRAIN
  input  logic [CNT_W-1:0] i_stepLen,  // requested step length
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_first2,
  output logic             o_first1,
  output logic             o_last2,
  output logic             o_last1
);

  localparam logic [CNT_W-1:0] LEN_FLOOR = CNT_W'(LEN_MIN);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_len_req;
  logic             w_at_end;

  // Requested length clamped up to the minimum usable step length
  assign w_len_req = (i_stepLen < LEN_FLOOR) ? LEN_FLOOR : i_stepLen;
  assign w_at_end  = (r_cnt == r_len - CNT_W'(1));

  // Step counter and length latch, advanced on the falling edge
  always_ff @(negedge clk or negedge nRst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nRst) begin
      r_cnt <= '0;
      r_len <= LEN_FLOOR;
    end else if (i_start) begin
      r_cnt <= '0;
      r_len <= w_len_req;
    end else if (i_active) begin
      if (w_at_end) begin
        r_cnt <= '0;
        r_len <= w_len_req;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_cnt = r_cnt;

  // Strobe decode of registered count against latched length, gated by activity
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_first2 = 1'b0;
    o_first1 = 1'b0;
    o_last2  = 1'b0;
    o_last1  = 1'b0;
    if (i_active) begin
      o_first2 = (r_cnt == '0);
      o_first1 = (r_cnt == CNT_W'(1));
      o_last2  = (r_cnt == r_len - CNT_W'(2));
      o_last1  = w_at_end;
    end
  end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer: 12-step commutation sequencer for the 3-phase PWM
// datapath. IDLE/RUN/DRAIN control with sgStep generation; the per-step
// timebase lives in motoro3_step_timebase. State updates on the falling edge.
// Optional feature macro: M3SEQ_HALFCYCLE_CNT_EN adds the halfCycleCnt output.
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int CNT_W   = 25,
  parameter int LEN_MIN = LEN_MIN_DEFAULT
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             enable,
  input  logic [CNT_W-1:0] m3r_stepLen,
  output logic [3:0]       sgStep,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntFirst2,
  output logic             m3cntFirst1,
  output logic             m3cntLast2,
  output logic             m3cntLast1,
  output logic             pwmActive1,
  output logic             pwmLastStep1,
  output logic             busy
`ifdef M3SEQ_HALFCYCLE_CNT_EN
  ,
  output logic [15:0]      halfCycleCnt
`endif
);

  m3_state_t  r_state;
  logic [3:0] r_step;
  logic       w_active;
  logic       w_start;
  logic       w_last1;

  assign w_active = (r_state != ST_IDLE);
  assign w_start  = (r_state == ST_IDLE) && enable;

  motoro3_step_timebase #(
    .CNT_W   (CNT_W),
    .LEN_MIN (LEN_MIN)
  ) u_timebase (
    .clk       (clk),
    .nRst      (nRst),
    .i_start   (w_start),
    .i_active  (w_active),
    .i_stepLen (m3r_stepLen),
    .o_cnt     (m3cnt),
    .o_first2  (m3cntFirst2),
    .o_first1  (m3cntFirst1),
    .o_last2   (m3cntLast2),
    .o_last1   (w_last1)
  );

  // Run/drain control and step index; drain only stops at a half-cycle end
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_INACTIVE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_RUN;
            r_step  <= STEP_FIRST;
          end
        end
        ST_RUN: begin
          if (w_last1) r_step <= next_step(r_step);
          if (!enable) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enable) begin
            r_state <= ST_RUN;
            if (w_last1) r_step <= next_step(r_step);
          end else if (w_last1) begin
            if (is_half_end(r_step)) begin
              r_state <= ST_IDLE;
              r_step  <= STEP_INACTIVE;
            end else begin
              r_step <= next_step(r_step);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_step  <= STEP_INACTIVE;
        end
      endcase
    end
  end

  assign sgStep       = r_step;
  assign m3cntLast1   = w_last1;
  assign pwmActive1   = w_active;
  assign busy         = w_active;
  assign pwmLastStep1 = is_half_end(r_step);

`ifdef M3SEQ_HALFCYCLE_CNT_EN
  logic [15:0] r_half_cnt;

  // Half-cycle counter: cleared on start, bumped at the end of steps 5 and 11
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      r_half_cnt <= '0;
    end else if (w_start) begin
      r_half_cnt <= '0;
    end else if (w_last1 && is_half_end(r_step)) begin
      r_half_cnt <= r_half_cnt + 16'd1;
    end
  end

  assign halfCycleCnt = r_half_cnt;
`endif

endmodule

// File: doc/motoro3_step_sequencer.md
# motoro3_step_sequencer

Commutation step sequencer for the 3-phase motor datapath. Generates the 12-step commutation index and the per-step timebase (step counter plus first/last strobes), and gates the PWM generators on and off at half-cycle boundaries. Sits upstream of every per-phase PWM generator, which consume its outputs directly; runs on the 10 MHz system clock.

## Interface

Parameters:
- CNT_W, 25, width of step counter and step length
- LEN_MIN, 4, minimum effective step length in clocks

Ports:
- clk  input  1  system clock, 10 MHz; all state updates on the falling edge
- nRst  input  1  reset, asynchronous, active-low
- enable  input  1  run request; level-sensitive
- m3r_stepLen  input  CNT_W  requested step length in clocks
- sgStep  output  4  commutation step 0..11; 15 = inactive
- m3cnt  output  CNT_W  clock count within current step
- m3cntFirst2  output  1  high when m3cnt == 0
- m3cntFirst1  output  1  high when m3cnt == 1
- m3cntLast2  output  1  high when m3cnt == len-2
- m3cntLast1  output  1  high when m3cnt == len-1
- pwmActive1  output  1  high in RUN and DRAIN
- pwmLastStep1  output  1  high while sgStep is 5 or 11
- busy  output  1  state != IDLE

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE: sgStep = 15, m3cnt = 0, all strobes 0. On enable = 1: go RUN, sgStep <= 0, m3cnt <= 0, len <= max(m3r_stepLen, LEN_MIN).
- RUN: m3cnt increments each clock. At m3cnt == len-1: m3cnt <= 0, sgStep <= (sgStep == 11) ? 0 : sgStep+1, len re-latched from m3r_stepLen (clamped). If enable == 0: go DRAIN (step continues unaffected).
- DRAIN: counting as RUN. enable == 1 returns to RUN with no disturbance. At m3cnt == len-1 with sgStep 5 or 11: go IDLE.
- Step length is sampled only at IDLE exit and step boundaries; mid-step changes of m3r_stepLen have no effect on the current step.
- Strobes are combinational decodes of registered m3cnt and latched len, gated by pwmActive1; exactly one cycle each per step. With len = LEN_MIN all four strobes are distinct.
- Unsigned arithmetic throughout; m3cnt never exceeds len-1.

## Timing

- Reset values: sgStep 4'd15, m3cnt 0, all strobes 0, pwmActive1 0, pwmLastStep1 0, busy 0; len register = LEN_MIN.
- nRst assertion mid-step returns all outputs to reset values immediately, no drain.
- enable to first RUN cycle: 1 falling edge; first RUN cycle shows m3cnt = 0, m3cntFirst2 = 1.
- Step period exactly len clocks; full electrical cycle 12 × len when len constant.
- Drop of enable to IDLE: up to 6 steps (completes current half-cycle).

## Configuration

- M3SEQ_HALFCYCLE_CNT_EN: defined adds output halfCycleCnt[15:0], incremented at each Last1 of step 5 or 11, cleared on IDLE exit, wraps at 16'hFFFF, reset 0. Undefined: port and counter absent; all other behaviour identical.

## Structure

- Shared package motoro3_pkg: state enum (IDLE/RUN/DRAIN), STEP_INACTIVE = 4'd15, STEP_LAST = 4'd11, half-cycle end steps 5 and 11, LEN_MIN default.
- One natural sub-module: motoro3_step_timebase (m3cnt counter, len latch/clamp, strobe decode); FSM and sgStep in the top.

## Test plan

- Reset, m3r_stepLen = 10, enable = 1 -> first RUN cycle m3cnt 0/First2; m3cnt 1/First1; 8/Last2; 9/Last1; next cycle sgStep 1, m3cnt 0.
- Hold enable, len 10 -> sgStep returns to 0 after 120 clocks; pwmLastStep1 high for clocks 50–59 and 110–119.
- m3r_stepLen = 2 -> step period 4 clocks, strobes at m3cnt 0,1,2,3.
- enable dropped during step 2 -> stepping continues through step 5 Last1, then sgStep 15, pwmActive1 0, busy 0; re-assert during step 4 -> no IDLE, stepping continues.
- m3r_stepLen 10 -> 20 at m3cnt 4 of step 3 -> step 3 lasts 10 clocks, step 4 lasts 20.
- nRst pulsed at m3cnt 5 of step 7 -> all outputs at reset values before next clock edge; with M3SEQ_HALFCYCLE_CNT_EN, halfCycleCnt 0.
